clock_timekeeper: RTL and testbench
===================================

Name: clock_timekeeper

Overview:
Parametrised successor to the single seconds counter. Derives a 1 Hz tick from the system clock with a programmable prescaler, and keeps BCD seconds, minutes and hours with carry chaining and a 24h or 12h mode. Accepts a synchronous time-set request and drives a multiplexed 7-segment display scanning up to 6 digits. Sits at top level between the pad inputs and `uo_out` / `uio_out`.

Parameters:
- TICK_DIV, 65536: system clocks per second tick; legal range 2..2^24.
- SCAN_DIV, 1024: system clocks per display digit slot; legal range 2..2^16.
- DIGITS, 4: digits scanned. 4 shows HH:MM; 6 shows HH:MM:SS. Other values are illegal.
- HOUR_24, 1: 1 selects hours 00..23; 0 selects hours 01..12.

Ports:
- clock, in, 1: system clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- set_valid, in, 1: one-cycle time-set strobe.
- set_field, in, 2: field to set. 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved.
- set_value, in, 8: BCD value to load; [7:4] is tens, [3:0] is units.
- set_err, out, 1: one-cycle pulse when a set request is rejected.
- sec_pulse, out, 1: one-cycle pulse on each seconds increment.
- sec_bcd, out, 8: seconds in BCD.
- min_bcd, out, 8: minutes in BCD.
- hour_bcd, out, 8: hours in BCD.
- segment, out, 7: active-high segments; bit0 = a through bit6 = g.
- digit_sel, out, DIGITS: one-hot, active-high digit enable; bit0 is the rightmost digit.

Behaviour:
- Reset values:
  - Prescaler and scan counter: 0.
  - sec_bcd and min_bcd: 8'h00.
  - hour_bcd: 8'h00 when HOUR_24 = 1, 8'h12 when HOUR_24 = 0.
  - sec_pulse and set_err: 0.
  - digit_sel: 1 (digit 0 selected).
  - segment: pattern for the reset value of digit 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for the single cycle in which the count equals TICK_DIV-1.
- Timekeeping, registered on the cycle tick is high:
  - sec_pulse=1 that cycle.
  - Seconds count units 0-9 and tens 0-5. 59 wraps to 00 and carries into minutes in the same cycle.
  - Minutes follow the same rule and carry into hours at 59.
  - Hours (24h): 23 wraps to 00.
  - Hours (12h): 12 goes to 01; 11 goes to 12. There is no AM/PM flag.
  - All carries resolve in one cycle; 23:59:59 becomes 00:00:00 on a single tick.
- Set request, sampled when set_valid = 1:
  - Accepted if set_field is 0..2, both nibbles are at most 9, and the value lies in the field's range: 0..59 for seconds and minutes, 0..23 (24h) or 1..12 (12h) for hours.
  - Accepted: the field loads the value on the next edge.
  - Rejected: set_err pulses on the next edge and no state changes.
  - Setting seconds also clears the prescaler, so the next tick comes TICK_DIV cycles later.
- Set and tick in the same cycle:
  - The set field takes set_value.
  - A carry into the set field is dropped.
  - Fields below the set field still increment normally.
  - Fields above the set field receive no carry out of the set field.
  - sec_pulse still fires.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, digit_sel rotates left by one, from bit DIGITS-1 back to bit0.
  - Digit map: 0 = minutes units, 1 = minutes tens, 2 = hours units, 3 = hours tens.
  - With DIGITS=6 the map shifts: 0–1 are seconds units and tens, 2–3 are minutes, 4–5 are hours.
  - segment is combinational from the selected nibble via a hex decoder; a is bit0 and g is bit6. Nibbles A–F show hex glyphs and cannot occur in normal operation.
- Reset mid-operation: all state returns to its reset value immediately (asynchronous); any set in flight is discarded.

Optional Feature:
- Macro name: CLOCK_TIMEKEEPER_ALARM_EN.
- Defined:
  - set_field=3 is legal and loads the alarm register as HH:MM, taking hours from set_value and minutes from the current min_bcd.
  - Adds output alarm_hit (1 bit), registered. It pulses for one cycle when a tick makes hour:min equal the alarm value with seconds becoming 00.
  - The alarm register resets to hour 8'h00 (24h) or 8'h12 (12h).
- Undefined: set_field=3 is rejected with set_err, and the alarm_hit port is absent.

Decomposition:
- Package clock_timekeeper_pkg holds:
  - Field encodings: FIELD_SEC, FIELD_MIN, FIELD_HOUR, FIELD_ALARM.
  - BCD limit constants.
  - The 16-entry 7-bit segment lookup constant.
- One sub-module, seg7_decode: 4-bit nibble in, 7-bit segment out, combinational. It is shared with other display blocks.
- The BCD increment-with-limit logic may be a function in the package.

Test Plan:
- Reset and count (TICK_DIV=4, HOUR_24=1): hold reset, then release. Outputs are 00:00:00 and sec_pulse first fires on cycle 4. After 4×60 cycles, sec_bcd=8'h00 and min_bcd=8'h01.
- Full rollover: set hours to 8'h23, minutes to 8'h59, seconds to 8'h59, then wait one tick. The next tick gives 00:00:00 in a single cycle.
- 12h mode (HOUR_24=0): reset gives hour 8'h12. Minute carry gives 8'h01; from 8'h11, minute carry gives 8'h12. Setting hours to 8'h00 or 8'h13 gives set_err=1 and hours unchanged.
- Illegal BCD: set_field=1 with set_value=8'h5A or 8'h60 gives set_err pulse and min_bcd unchanged. set_field=3 without the macro also gives set_err.
- Set/tick collision: with seconds at 8'h59, set minutes to 8'h30 in the tick cycle. Result is sec_bcd=8'h00 and min_bcd=8'h30 (carry dropped).
- Scan (SCAN_DIV=2, DIGITS=4, time 12:34): digit_sel sequence is 0001, 0010, 0100, 1000, changing every 2 cycles. segment is 7'h66 ('4'), 7'h4F ('3'), 7'h5B ('2'), 7'h06 ('1').

Source files
------------

// File: rtl/clock_timekeeper_pkg.sv
// clock_timekeeper_pkg
// Shared definitions for the BCD timekeeper:
//   - set-request field encodings
//   - BCD range limits for seconds, minutes and hours
//   - 16-entry hex glyph table for a 7-segment display (bit0 = a .. bit6 = g)
//   - BCD increment helpers used by the carry chain
package clock_timekeeper_pkg;

    typedef enum logic [1:0] {
        FIELD_SEC   = 2'd0,
        FIELD_MIN   = 2'd1,
        FIELD_HOUR  = 2'd2,
        FIELD_ALARM = 2'd3
    } field_e;

    localparam logic [7:0] SEC_MAX    = 8'h59;
    localparam logic [7:0] MIN_MAX    = 8'h59;
    localparam logic [7:0] HOUR24_MAX = 8'h23;
    localparam logic [7:0] HOUR12_MIN = 8'h01;
    localparam logic [7:0] HOUR12_MAX = 8'h12;

    // Entry n sits at bits [7n+6:7n]; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Both nibbles must be decimal digits.
    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_in_range(input logic [7:0] v, input logic h24);
        if (h24)
            return v <= HOUR24_MAX;
        return (v >= HOUR12_MIN) && (v <= HOUR12_MAX);
    endfunction

    // Plain BCD +1 with no upper limit.
    function automatic logic [7:0] bcd_step(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {carry, next}; wraps to 00 and carries when v equals lim.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return {1'b1, 8'h00};
        return {1'b0, bcd_step(v)};
    endfunction

    // Hours never carry further; 12h mode runs 12 -> 01 -> ... -> 11 -> 12.
    function automatic logic [7:0] hour_next(input logic [7:0] v, input logic h24);
        if (h24)
            return (v == HOUR24_MAX) ? 8'h00 : bcd_step(v);
        return (v == HOUR12_MAX) ? HOUR12_MIN : bcd_step(v);
    endfunction

endpackage

// File: rtl/clock_timekeeper_seg7_decode.sv
// seg7_decode
// Combinational hex nibble to 7-segment decoder, active-high segments.
// Ports:
//   nibble_i  [3:0]  value to show (0..F)
//   segment_o [6:0]  segment drive, bit0 = a .. bit6 = g
module seg7_decode
    import clock_timekeeper_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segment_o
);

    assign segment_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper
// Prescaled 1 Hz tick, BCD seconds/minutes/hours with single-cycle carry
// chaining (24h or 12h), synchronous time-set with range checking, and a
// multiplexed 7-segment scan of 4 (HH:MM) or 6 (HH:MM:SS) digits.
// Optional alarm compare when CLOCK_TIMEKEEPER_ALARM_EN is defined.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   set_valid/field/value     one-cycle set request (BCD value)
//   set_err                   one-cycle pulse on a rejected request
//   sec_pulse                 one-cycle pulse on each seconds increment
//   sec_bcd/min_bcd/hour_bcd  current time in BCD
//   segment, digit_sel        display scan outputs (digit_sel one-hot)
//   alarm_hit                 (alarm build only) alarm match pulse
module clock_timekeeper
    import clock_timekeeper_pkg::*;
#(
    parameter int TICK_DIV = 65536,
    parameter int SCAN_DIV = 1024,
    parameter int DIGITS   = 4,
    parameter int HOUR_24  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_valid,
    input  logic [1:0]        set_field,
    input  logic [7:0]        set_value,
    output logic              set_err,
    output logic              sec_pulse,
    output logic [7:0]        sec_bcd,
    output logic [7:0]        min_bcd,
    output logic [7:0]        hour_bcd,
    output logic [6:0]        segment,
    output logic [DIGITS-1:0] digit_sel
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    ,
    output logic              alarm_hit
`endif
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic          H24       = (HOUR_24 != 0);
    localparam logic [7:0]    HOUR_RST  = H24 ? 8'h00 : 8'h12;

    logic [TW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]        sec_q, sec_d;
    logic [7:0]        min_q, min_d;
    logic [7:0]        hour_q, hour_d;
    logic              sec_pulse_q, set_err_q;

    logic       tick;
    logic       set_ok;
    logic       sec_cy, min_cy;
    logic [7:0] sec_inc, min_inc, hour_inc;
    logic [3:0] digit_nib;
    logic [3:0] nib [6];

    assign tick = (presc_q == TICK_LAST);

    always_comb begin
        set_ok = 1'b0;
        if (set_valid && bcd_digits_ok(set_value)) begin
            case (field_e'(set_field))
                FIELD_SEC:   set_ok = (set_value <= SEC_MAX);
                FIELD_MIN:   set_ok = (set_value <= MIN_MAX);
                FIELD_HOUR:  set_ok = hour_in_range(set_value, H24);
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
                FIELD_ALARM: set_ok = hour_in_range(set_value, H24);
`else
                FIELD_ALARM: set_ok = 1'b0;
`endif
                default:     set_ok = 1'b0;
            endcase
        end
    end

    assign {sec_cy, sec_inc} = bcd_inc(sec_q, SEC_MAX);
    assign {min_cy, min_inc} = bcd_inc(min_q, MIN_MAX);
    assign hour_inc          = hour_next(hour_q, H24);

    // A set overrides its own field and blocks the carry out of it, while
    // lower fields still advance on a coincident tick.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick) begin
            sec_d = sec_inc;
            if (sec_cy) begin
                min_d = min_inc;
                if (min_cy)
                    hour_d = hour_inc;
            end
        end
        if (set_ok) begin
            case (field_e'(set_field))
                FIELD_SEC: begin
                    sec_d  = set_value;
                    min_d  = min_q;
                    hour_d = hour_q;
                end
                FIELD_MIN: begin
                    min_d  = set_value;
                    hour_d = hour_q;
                end
                FIELD_HOUR: hour_d = set_value;
                default: ;
            endcase
        end
    end

    // Loading seconds restarts the second so the next tick is a full period away.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (set_ok && (field_e'(set_field) == FIELD_SEC))
            presc_d = '0;
    end

    always_comb begin
        scan_d      = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (scan_q == SCAN_LAST)
            digit_sel_d = {digit_sel_q[DIGITS-2:0], digit_sel_q[DIGITS-1]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            scan_q      <= '0;
            digit_sel_q <= DIGITS'(1);
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= HOUR_RST;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            digit_sel_q <= digit_sel_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_pulse_q <= tick;
            set_err_q   <= set_valid && !set_ok;
        end
    end

`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    logic [15:0] alarm_q, alarm_d;
    logic        alarm_hit_q, alarm_hit_d;

    // Alarm hours come from the request; minutes are captured from the live clock.
    always_comb begin
        alarm_d = alarm_q;
        if (set_ok && (field_e'(set_field) == FIELD_ALARM))
            alarm_d = {set_value, min_q};
        alarm_hit_d = tick && (sec_d == 8'h00) && ({hour_d, min_d} == alarm_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_q     <= {HOUR_RST, 8'h00};
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`endif

    // Digit 0 is the rightmost position; 6-digit builds add seconds on the right.
    always_comb begin
        if (DIGITS == 6) begin
            nib[0] = sec_q[3:0];
            nib[1] = sec_q[7:4];
            nib[2] = min_q[3:0];
            nib[3] = min_q[7:4];
            nib[4] = hour_q[3:0];
            nib[5] = hour_q[7:4];
        end else begin
            nib[0] = min_q[3:0];
            nib[1] = min_q[7:4];
            nib[2] = hour_q[3:0];
            nib[3] = hour_q[7:4];
            nib[4] = 4'h0;
            nib[5] = 4'h0;
        end
        digit_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel_q[i])
                digit_nib = digit_nib | nib[i];
        end
    end

    seg7_decode u_seg7_decode (
        .nibble_i  (digit_nib),
        .segment_o (segment)
    );

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign hour_bcd  = hour_q;
    assign sec_pulse = sec_pulse_q;
    assign set_err   = set_err_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper
// Two instances share stimulus: a 24h HH:MM build and a 12h HH:MM:SS build.
// Each is compared every cycle against a seconds-of-day reference model.
module tb_clock_timekeeper;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       set_valid;
    logic [1:0] set_field;
    logic [7:0] set_value;

    logic       se24, sp24, se12, sp12;
    logic [7:0] s24, m24, h24, s12, m12, h12;
    logic [6:0] seg24, seg12;
    logic [3:0] dsel24;
    logic [5:0] dsel12;

    int n_checks = 0;
    int n_pass   = 0;

    int sd_a  [2] = '{2, 3};
    int dg_a  [2] = '{4, 6};
    int h24_a [2] = '{1, 0};

    int m_s [2], m_m [2], m_h [2], m_p [2], m_sc [2], m_di [2];
    bit e_sp [2], e_se [2];

    always #5 clock = ~clock;

    clock_timekeeper #(.TICK_DIV(TD), .SCAN_DIV(2), .DIGITS(4), .HOUR_24(1)) u_dut24 (
        .clock(clock), .reset(reset), .set_valid(set_valid), .set_field(set_field),
        .set_value(set_value), .set_err(se24), .sec_pulse(sp24), .sec_bcd(s24),
        .min_bcd(m24), .hour_bcd(h24), .segment(seg24), .digit_sel(dsel24)
    );

    clock_timekeeper #(.TICK_DIV(TD), .SCAN_DIV(3), .DIGITS(6), .HOUR_24(0)) u_dut12 (
        .clock(clock), .reset(reset), .set_valid(set_valid), .set_field(set_field),
        .set_value(set_value), .set_err(se12), .sec_pulse(sp12), .sec_bcd(s12),
        .min_bcd(m12), .hour_bcd(h12), .segment(seg12), .digit_sel(dsel12)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit set_ok(input int i, input logic [1:0] f, input logic [7:0] v);
        int t, u, n;
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        if (t > 9 || u > 9) return 0;
        n = t * 10 + u;
        case (f)
            2'd0, 2'd1: return n <= 59;
            2'd2:       return (h24_a[i] != 0) ? (n <= 23) : (n >= 1 && n <= 12);
            default:    return 0;
        endcase
    endfunction

    function automatic int exp_nib(input int i);
        int f, val;
        f = m_di[i] / 2 + ((dg_a[i] == 6) ? 0 : 1);
        val = (f == 0) ? m_s[i] : (f == 1) ? m_m[i] : m_h[i];
        return (m_di[i] % 2 == 0) ? val % 10 : val / 10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = 0; m_m[i] = 0;
            m_h[i] = (h24_a[i] != 0) ? 0 : 12;
            m_p[i] = 0; m_sc[i] = 0; m_di[i] = 0;
            e_sp[i] = 0; e_se[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit tick, ok;
            int ns, nm, nh, tot, n;
            tick = (m_p[i] == TD - 1);
            ok = set_valid && set_ok(i, set_field, set_value);
            e_sp[i] = tick;
            e_se[i] = set_valid && !ok;
            ns = m_s[i]; nm = m_m[i]; nh = m_h[i];
            if (tick) begin
                if (h24_a[i] != 0)
                    tot = (nh * 3600 + nm * 60 + ns + 1) % 86400;
                else
                    tot = ((nh % 12) * 3600 + nm * 60 + ns + 1) % 43200;
                nh = tot / 3600;
                nm = (tot / 60) % 60;
                ns = tot % 60;
                if (h24_a[i] == 0 && nh == 0) nh = 12;
            end
            if (ok) begin
                n = int'(set_value[7:4]) * 10 + int'(set_value[3:0]);
                case (set_field)
                    2'd0: begin ns = n; nm = m_m[i]; nh = m_h[i]; end
                    2'd1: begin nm = n; nh = m_h[i]; end
                    default: nh = n;
                endcase
            end
            m_s[i] = ns; m_m[i] = nm; m_h[i] = nh;
            m_p[i] = tick ? 0 : m_p[i] + 1;
            if (ok && set_field == 2'd0) m_p[i] = 0;
            if (m_sc[i] == sd_a[i] - 1) begin
                m_sc[i] = 0;
                m_di[i] = (m_di[i] + 1) % dg_a[i];
            end else begin
                m_sc[i]++;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [7:0] s, input logic [7:0] m,
                              input logic [7:0] h, input logic sp, input logic se,
                              input logic [6:0] seg, input int dsel);
        check_val($sformatf("d%0d_sec", i), 32'(s), 32'(to_bcd(m_s[i])));
        check_val($sformatf("d%0d_min", i), 32'(m), 32'(to_bcd(m_m[i])));
        check_val($sformatf("d%0d_hour", i), 32'(h), 32'(to_bcd(m_h[i])));
        check_val($sformatf("d%0d_sec_pulse", i), 32'(sp), 32'(e_sp[i]));
        check_val($sformatf("d%0d_set_err", i), 32'(se), 32'(e_se[i]));
        check_val($sformatf("d%0d_digit_sel", i), 32'(dsel), 32'(1 << m_di[i]));
        check_val($sformatf("d%0d_segment", i), 32'(seg), 32'(glyph(exp_nib(i))));
    endtask

    task automatic check_all();
        check_inst(0, s24, m24, h24, sp24, se24, seg24, int'(dsel24));
        check_inst(1, s12, m12, h12, sp12, se12, seg12, int'(dsel12));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_set(input logic [1:0] f, input logic [7:0] v);
        set_valid = 1'b1;
        set_field = f;
        set_value = v;
        step();
        set_valid = 1'b0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_valid = 1'b0;
        set_field = 2'd0;
        set_value = 8'h00;
        #2;
        model_reset();
        check_all();
        check_val("rst_hour12", 32'(h12), 32'h12);
        reset = 1'b0;

        // free run: one minute of ticks
        idle(TD * 60);
        check_val("count_min", 32'(m24), 32'h01);
        check_val("count_sec", 32'(s24), 32'h00);

        // full rollover (12h instance rejects hour 23)
        do_set(2'd2, 8'h23);
        do_set(2'd1, 8'h59);
        do_set(2'd0, 8'h59);
        idle(TD);
        check_val("roll_hour", 32'(h24), 32'h00);
        check_val("roll_min", 32'(m24), 32'h00);
        check_val("roll_sec", 32'(s24), 32'h00);
        check_val("roll12_hour", 32'(h12), 32'h01);

        // 12h: 11 -> 12 on carry, then out-of-range hours
        do_set(2'd2, 8'h11);
        do_set(2'd1, 8'h59);
        do_set(2'd0, 8'h59);
        idle(TD);
        check_val("h12_11to12", 32'(h12), 32'h12);
        do_set(2'd2, 8'h00);
        check_val("h12_set00_err", 32'(se12), 32'h1);
        do_set(2'd2, 8'h13);
        check_val("h12_set13_err", 32'(se12), 32'h1);
        check_val("h12_unchanged", 32'(h12), 32'h12);

        // illegal BCD and reserved field
        do_set(2'd1, 8'h5A);
        check_val("bcd_5A_err", 32'(se24), 32'h1);
        do_set(2'd1, 8'h60);
        check_val("bcd_60_err", 32'(se24), 32'h1);
        do_set(2'd3, 8'h12);
        check_val("field3_err", 32'(se24), 32'h1);

        // set minutes in the tick cycle that would carry out of 59 seconds
        do_set(2'd0, 8'h59);
        idle(TD - 1);
        do_set(2'd1, 8'h30);
        check_val("coll_sec", 32'(s24), 32'h00);
        check_val("coll_min", 32'(m24), 32'h30);
        check_val("coll_pulse", 32'(sp24), 32'h1);

        // scan at 12:34
        do_set(2'd2, 8'h12);
        do_set(2'd1, 8'h34);
        idle(16);

        // randomized sets with occasional asynchronous reset
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 999) == 0)
                async_reset();
            if ($urandom_range(0, 4) == 0) begin
                logic [7:0] v;
                if ($urandom_range(0, 1) == 1)
                    v = to_bcd(int'($urandom_range(0, 65)));
                else
                    v = 8'($urandom);
                do_set(2'($urandom_range(0, 3)), v);
            end else begin
                step();
            end
        end
        async_reset();
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
